// File: rtl/inst_fetch_pkg.sv
// Shared core definitions for the fetch stage and the decoder that follows it.
// Contents: the fetch FSM state encoding, the NOP word and the default reset PC,
// the base-ISA major opcodes, and a helper that word-aligns an address.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HOLD  = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory read port: single-word reads with a req/ready handshake.
//   req   : read request (fetch -> memory)
//   addr  : word address, bits [1:0] always 00 (fetch -> memory)
//   ready : read completes this cycle, rdata valid (memory -> fetch)
//   rdata : instruction word (memory -> fetch)
// The master modport is the fetch stage; the slave modport is the memory.
interface inst_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage. Holds the PC, issues single-word reads on the
// instruction memory port and registers the returned word for the decoder.
// Redirects (branch/jump/IRQ) are accepted in any state, including while a
// read is in flight; the in-flight response is then drained and dropped.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   mem          : instruction memory read port (master side)
//   inst         : registered instruction word (NOP_INST when not valid)
//   inst_pc      : PC of inst
//   inst_valid   : inst/inst_pc hold a live instruction
//   next         : decoder accepts the current instruction
//   redirect     : load redirect_pc and discard held/in-flight instruction
//   redirect_pc  : redirect target; low two bits are dropped
//   misalign     : one-cycle pulse, accepted redirect_pc was not word aligned
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FETCH | read of pc requested, waiting for mem.ready
// ST_HOLD  | word held on inst, waiting for next or redirect
// ST_FLUSH | redirected while a read was in flight; draining the stale read
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_if.master        mem,
    output logic [31:0]         inst,
    output logic [31:0]         inst_pc,
    output logic                inst_valid,
    input  logic                next,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                misalign
);

    fetch_state_t state, state_n;

    logic [31:0] pc, pc_n;
    logic [31:0] req_addr, req_addr_n;
    logic        mem_req_q, mem_req_n;
    logic [31:0] inst_n;
    logic [31:0] inst_pc_n;
    logic        inst_valid_n;
    logic        misalign_n;
    logic        mem_done;
    logic [31:0] target_pc;

    // mem_req and mem_addr come straight from flops so the memory never sees
    // a combinational path back from its own ready.
    assign mem.req  = mem_req_q;
    assign mem.addr = req_addr;

    // A ready is only meaningful against a request we actually issued; the
    // first cycle after reset has mem_req low.
    assign mem_done  = mem_req_q & mem.ready;
    assign target_pc = word_align(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_addr_n   = req_addr;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_valid_n = inst_valid;

        case (state)
            ST_FETCH: begin
                if (redirect) begin
                    pc_n = target_pc;
                    // Outstanding read with no response yet must be drained.
                    if (mem_req_q && !mem.ready) begin
                        state_n = ST_FLUSH;
                    end
                end else if (mem_done) begin
                    inst_n       = mem.rdata;
                    inst_pc_n    = pc;
                    inst_valid_n = 1'b1;
                    state_n      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_n         = target_pc;
                    inst_n       = NOP_INST;
                    inst_valid_n = 1'b0;
                    state_n      = ST_FETCH;
                end else if (next) begin
                    pc_n         = pc + 32'd4;
                    inst_n       = NOP_INST;
                    inst_valid_n = 1'b0;
                    state_n      = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (redirect) begin
                    pc_n = target_pc;
                end
                if (mem_done) begin
                    state_n = ST_FETCH;
                end
            end
            default: begin
                state_n = ST_FETCH;
            end
        endcase

        // In FLUSH the bus must keep presenting the stale address until its
        // response arrives, so req_addr only follows pc when entering FETCH.
        if (state_n == ST_FETCH) begin
            req_addr_n = pc_n;
        end

        mem_req_n  = (state_n != ST_HOLD);
        misalign_n = redirect & (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            mem_req_q  <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            pc         <= pc_n;
            req_addr   <= req_addr_n;
            mem_req_q  <= mem_req_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            inst_valid <= inst_valid_n;
            misalign   <= misalign_n;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch. A small memory responder returns
// addr ^ 32'h0050_0193 after a programmable number of wait states.
// Inputs change and outputs are sampled on the falling edge.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;

    int n_checks;
    int n_pass;
    int wait_states;
    int wait_cnt;

    inst_fetch_if mem_if ();

    inst_fetch #(
        .RESET_PC (32'h0000_0100),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem_if),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .next        (next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_if.ready = mem_if.req && (wait_cnt == wait_states);
    assign mem_if.rdata = mem_if.addr ^ 32'h0050_0193;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (!mem_if.req || mem_if.ready) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        wait_states = 0;
        rst         = 1'b1;
        next        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        step();
        step();
        chk("rst_req",   {31'b0, mem_if.req}, 32'd0);
        chk("rst_inst",  inst,                32'h0000_0013);
        chk("rst_ipc",   inst_pc,             32'h0000_0100);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_mis",   {31'b0, misalign},   32'd0);

        // Reset release, zero-wait memory.
        rst = 1'b0;
        step();                                   // edge 1
        chk("e1_req",   {31'b0, mem_if.req}, 32'd1);
        chk("e1_addr",  mem_if.addr,         32'h0000_0100);
        chk("e1_valid", {31'b0, inst_valid}, 32'd0);
        step();                                   // edge 2
        chk("e2_inst",  inst,                32'h0050_0093);
        chk("e2_ipc",   inst_pc,             32'h0000_0100);
        chk("e2_valid", {31'b0, inst_valid}, 32'd1);
        chk("e2_req",   {31'b0, mem_if.req}, 32'd0);

        // Sequential stream with next held high.
        next = 1'b1;
        step();                                   // edge 3
        chk("s1_addr",  mem_if.addr,         32'h0000_0104);
        chk("s1_valid", {31'b0, inst_valid}, 32'd0);
        chk("s1_inst",  inst,                32'h0000_0013);
        step();                                   // edge 4
        chk("s2_valid", {31'b0, inst_valid}, 32'd1);
        chk("s2_ipc",   inst_pc,             32'h0000_0104);
        chk("s2_inst",  inst,                32'h0050_0097);
        step();                                   // edge 5
        chk("s3_addr",  mem_if.addr,         32'h0000_0108);
        chk("s3_valid", {31'b0, inst_valid}, 32'd0);
        next = 1'b0;
        step();                                   // edge 6
        chk("s4_valid", {31'b0, inst_valid}, 32'd1);
        chk("s4_inst",  inst,                32'h0050_009B);

        // 3 wait states at 0x200, redirect to 0x400 in the second wait cycle.
        wait_states = 3;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();                                   // edge 7
        redirect = 1'b0;
        chk("w0_addr",  mem_if.addr,         32'h0000_0200);
        chk("w0_valid", {31'b0, inst_valid}, 32'd0);
        step();                                   // edge 8
        chk("w1_addr",  mem_if.addr,         32'h0000_0200);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        step();                                   // edge 9
        redirect = 1'b0;
        chk("w2_addr",  mem_if.addr,         32'h0000_0200);
        chk("w2_req",   {31'b0, mem_if.req}, 32'd1);
        chk("w2_mis",   {31'b0, misalign},   32'd0);
        step();                                   // edge 10
        chk("w3_addr",  mem_if.addr,         32'h0000_0200);
        chk("w3_ready", {31'b0, mem_if.ready}, 32'd1);
        step();                                   // edge 11
        chk("w4_addr",  mem_if.addr,         32'h0000_0400);
        chk("w4_valid", {31'b0, inst_valid}, 32'd0);
        chk("w4_req",   {31'b0, mem_if.req}, 32'd1);
        wait_states = 0;
        step();                                   // edge 12
        chk("w5_valid", {31'b0, inst_valid}, 32'd1);
        chk("w5_ipc",   inst_pc,             32'h0000_0400);
        chk("w5_inst",  inst,                32'h0050_0593);

        // Redirect and next together in HOLD: redirect wins.
        redirect    = 1'b1;
        next        = 1'b1;
        redirect_pc = 32'h0000_0800;
        step();                                   // edge 13
        redirect = 1'b0;
        next     = 1'b0;
        chk("rn_addr",  mem_if.addr,         32'h0000_0800);
        chk("rn_valid", {31'b0, inst_valid}, 32'd0);
        step();                                   // edge 14
        chk("rn_ipc",   inst_pc,             32'h0000_0800);

        // Misaligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0302;
        step();                                   // edge 15
        redirect = 1'b0;
        chk("ma_pulse", {31'b0, misalign},   32'd1);
        chk("ma_addr",  mem_if.addr,         32'h0000_0300);
        step();                                   // edge 16
        chk("ma_clear", {31'b0, misalign},   32'd0);
        chk("ma_ipc",   inst_pc,             32'h0000_0300);
        chk("ma_inst",  inst,                32'h0050_0293);

        // Redirect in FETCH coinciding with mem_ready: data dropped.
        next = 1'b1;
        step();                                   // edge 17
        next = 1'b0;
        chk("fr_addr0", mem_if.addr,         32'h0000_0304);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0500;
        step();                                   // edge 18
        redirect = 1'b0;
        chk("fr_addr1", mem_if.addr,         32'h0000_0500);
        chk("fr_valid", {31'b0, inst_valid}, 32'd0);
        chk("fr_req",   {31'b0, mem_if.req}, 32'd1);
        step();                                   // edge 19
        chk("fr_ipc",   inst_pc,             32'h0000_0500);
        chk("fr_inst",  inst,                32'h0050_0493);

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();                                   // edge 20
        redirect = 1'b0;
        chk("wr_addr0", mem_if.addr,         32'hFFFF_FFFC);
        step();                                   // edge 21
        chk("wr_ipc",   inst_pc,             32'hFFFF_FFFC);
        chk("wr_inst",  inst,                32'hFFAF_FE6F);
        next        = 1'b1;
        wait_states = 3;
        step();                                   // edge 22
        next = 1'b0;
        chk("wr_addr1", mem_if.addr,         32'h0000_0000);
        step();                                   // edge 23, still waiting
        chk("wr_wait",  {31'b0, mem_if.req}, 32'd1);
        chk("wr_wvld",  {31'b0, inst_valid}, 32'd0);

        // Asynchronous reset mid-wait.
        #2 rst = 1'b1;
        #1;
        chk("ar_req",   {31'b0, mem_if.req}, 32'd0);
        chk("ar_valid", {31'b0, inst_valid}, 32'd0);
        chk("ar_inst",  inst,                32'h0000_0013);
        chk("ar_addr",  mem_if.addr,         32'h0000_0100);
        step();
        wait_states = 0;
        rst         = 1'b0;
        step();
        chk("ar_req1",  {31'b0, mem_if.req}, 32'd1);
        chk("ar_addr1", mem_if.addr,         32'h0000_0100);
        step();
        chk("ar_vld2",  {31'b0, inst_valid}, 32'd1);
        chk("ar_inst2", inst,                32'h0050_0093);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
